aes_gcm_block_scheduler: RTL and testbench
==========================================

AES_GCM_BLOCK_SCHEDULER -- requirements
Module: aes_gcm_block_scheduler

Interface
REQ-001 SHALL have parameter NUM_WORKERS, default 2: number of parallel encryption workers; legal values 1, 2, 4.
REQ-002 SHALL have parameter MAX_BLOCKS, default 100000: largest legal frame size in 128-bit blocks.
REQ-003 SHALL have parameter CNT_W, default 17: width of the block index.
REQ-004 SHALL have one clock and a synchronous, active-high reset, using these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- i_start  in  1  frame request; accepted when o_ready is 1.
- o_ready  out  1  scheduler is in IDLE.
- i_instance_size  in  128  bits [0:63] are the AAD length in bits; bits [64:127] are the text length in bits.
- i_stall  in  1  downstream backpressure.
- i_abort  in  1  abandons the current frame.
- o_valid  out  1  block descriptor valid.
- o_block_idx  out  CNT_W  global block index within the frame.
- o_worker_id  out  4  target worker.
- o_phase  out  3  block phase code.
- o_new_instance  out  1  first block of the frame.
- o_last_instance  out  1  final block of the frame.
- o_done  out  1  one-cycle pulse at frame end.
- o_error  out  1  one-cycle pulse when a frame is rejected for size.
- o_stat_frames  out  32  count of completed frames.
- o_stat_blocks  out  32  count of issued blocks.

Function
REQ-005 SHALL implement four states: IDLE, ISSUE, DONE and ERR.
REQ-006 In IDLE, i_start=1 SHALL latch i_instance_size and compute two values, using 64-bit unsigned arithmetic on the lengths:
- aad_blocks = AAD length >> 7.
- total_blocks = (AAD length + text length) >> 7.
REQ-007 The next state after a start in IDLE SHALL be:
- ERR when total_blocks > MAX_BLOCKS;
- DONE when total_blocks = 0;
- ISSUE otherwise, with the index set to 0.
REQ-008 In ISSUE, o_valid SHALL be 1, and o_block_idx SHALL equal the current index.
REQ-009 o_worker_id SHALL equal o_block_idx mod NUM_WORKERS.
REQ-010 o_phase SHALL be computed per block as follows:
- 010 when idx < aad_blocks, except for the final block.
- 000 when idx = aad_blocks, except for the final block.
- 001 when aad_blocks < idx < total_blocks-1.
- 011 when idx = total_blocks-1 and idx > aad_blocks.
- 111 when idx = total_blocks-1 and idx = aad_blocks.
- 110 when idx = total_blocks-1 and idx < aad_blocks (AAD-only frame).
REQ-011 o_new_instance SHALL be 1 exactly when o_valid is 1 and idx = 0.
REQ-012 o_last_instance SHALL be 1 exactly when o_valid is 1 and idx = total_blocks-1.
REQ-013 When i_stall=1, all outputs and the index SHALL hold unchanged, and o_valid SHALL stay at 1.
REQ-014 When i_stall=0, a block SHALL be issued and the index SHALL increment by 1.
REQ-015 After the final block is issued, the next state SHALL be DONE.
REQ-016 Throughput SHALL be one block per unstalled cycle; the first block SHALL appear the cycle after the start is accepted.
REQ-017 DONE SHALL assert o_done for one cycle, increment o_stat_frames, and then return to IDLE.
REQ-018 ERR SHALL assert o_error for one cycle with o_valid=0, and then return to IDLE.
REQ-019 i_abort=1 in any state SHALL force IDLE on the next cycle, with no o_done and o_valid=0 from that edge.
REQ-020 i_abort SHALL have priority over i_stall and over i_start.
REQ-021 i_start outside IDLE SHALL be ignored.
REQ-022 o_stat_blocks SHALL increment on each issued (unstalled, valid) block.
REQ-023 Both statistics counters SHALL wrap modulo 2^32.
REQ-024 A length whose value is not a multiple of 128 SHALL be truncated by the shifts in REQ-006, with no rounding up.

Reset
REQ-025 rst=1 SHALL force IDLE on the next rising edge of clk.
REQ-026 Under reset, the following outputs SHALL be 0:
- o_valid, o_block_idx, o_worker_id, o_new_instance, o_last_instance, o_done, o_error;
- o_stat_frames and o_stat_blocks.
REQ-027 Under reset, o_phase SHALL be 100 and o_ready SHALL be 1 from the first cycle after reset.
REQ-028 rst SHALL have priority over i_abort.
REQ-029 A frame in progress when rst is asserted SHALL be dropped without o_done.

Configuration
REQ-030 When macro AES_GCM_SCHED_STATS_EN is defined, o_stat_frames and o_stat_blocks SHALL count as in REQ-017, REQ-022 and REQ-023.
REQ-031 When AES_GCM_SCHED_STATS_EN is undefined, both statistics ports SHALL remain present and be constant 0, and no counter flops SHALL be synthesised.

Verification
REQ-032 AAD = 256 bits and text = 384 bits, no stall, NUM_WORKERS=2:
- the bench SHALL see 5 blocks, idx 0-4;
- worker ids SHALL be 0,1,0,1,0;
- phases SHALL be 010,010,000,001,011;
- new SHALL be set on idx 0 and last on idx 4;
- o_done SHALL pulse one cycle after idx 4.
REQ-033 AAD = 0 and text = 128 -> a single block with phase 111 and both new and last set.
REQ-034 AAD = 256 and text = 0 -> phases 010,110, with last set on idx 1.
REQ-035 Total = 100001 blocks -> o_error pulses once, o_valid stays 0 and o_ready returns next cycle; total = 0 -> o_done pulses once with no valid.
REQ-036 i_stall held high for 3 cycles while idx=2 -> idx 2 held for 4 cycles and the frame extended by 3 cycles.
REQ-037 i_abort at idx=1 -> IDLE next cycle with no o_done; a new i_start is then accepted and restarts at idx 0 with new set.
REQ-038 rst asserted mid-frame -> the reset values of REQ-026 and REQ-027 hold next cycle.
REQ-039 With the macro defined, the statistics read 2 frames and 6 blocks after the REQ-032 and REQ-033 frames run.

Source files
------------

// File: rtl/aes_gcm_block_scheduler.sv
// AES-GCM block scheduler: splits a frame (AAD + text lengths in bits) into 128-bit
// block descriptors spread round-robin over NUM_WORKERS. Optional statistics: AES_GCM_SCHED_STATS_EN.
module aes_gcm_block_scheduler #(
    parameter int NUM_WORKERS = 2,
    parameter int MAX_BLOCKS  = 100000,
    parameter int CNT_W       = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    output logic             o_ready,
    input  logic [127:0]     i_instance_size,
    input  logic             i_stall,
    input  logic             i_abort,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_block_idx,
    output logic [3:0]       o_worker_id,
    output logic [2:0]       o_phase,
    output logic             o_new_instance,
    output logic             o_last_instance,
    output logic             o_done,
    output logic             o_error,
    output logic [31:0]      o_stat_frames,
    output logic [31:0]      o_stat_blocks
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE, S_ERR} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] aad_q, aad_d;
    logic [CNT_W-1:0] fin_q, fin_d;
    logic             valid_q, valid_d;
    logic [3:0]       worker_q, worker_d;
    logic [2:0]       phase_q, phase_d;
    logic             new_q, new_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             ready_q, ready_d;
    logic             issue;

    logic [63:0] aad_len, txt_len, tot64, aadb64;

    always_comb begin
        aad_len = i_instance_size[63:0];
        txt_len = i_instance_size[127:64];
        tot64   = (aad_len + txt_len) >> 7;
        aadb64  = aad_len >> 7;

        state_d = state_q;
        idx_d   = idx_q;
        aad_d   = aad_q;
        fin_d   = fin_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b0;
        ready_d = 1'b0;
        issue   = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (i_start) begin
                    // An AAD count at or beyond the frame end behaves identically to one equal
                    // to the frame end, so clipping keeps the stored value within CNT_W bits.
                    aad_d = (aadb64 > tot64) ? tot64[CNT_W-1:0] : aadb64[CNT_W-1:0];
                    fin_d = tot64[CNT_W-1:0] - 1'b1;
                    ready_d = 1'b0;
                    if (tot64 > 64'(MAX_BLOCKS)) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else if (tot64 == 64'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        idx_d   = '0;
                        valid_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (i_stall) begin
                    valid_d = 1'b1;
                end else begin
                    issue = 1'b1;
                    if (idx_q == fin_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase

        if (i_abort) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            done_d  = 1'b0;
            error_d = 1'b0;
            ready_d = 1'b1;
            issue   = 1'b0;
        end

        // Descriptor fields are precomputed for the next cycle so every output is a flop.
        worker_d = 4'b0;
        phase_d  = 3'b100;
        new_d    = 1'b0;
        last_d   = 1'b0;
        if (valid_d) begin
            worker_d = {2'b00, idx_d[1:0] & 2'(NUM_WORKERS - 1)};
            new_d    = (idx_d == '0);
            last_d   = (idx_d == fin_d);
            if (idx_d == fin_d) begin
                if (idx_d > aad_d)       phase_d = 3'b011;
                else if (idx_d == aad_d) phase_d = 3'b111;
                else                     phase_d = 3'b110;
            end else begin
                if (idx_d < aad_d)       phase_d = 3'b010;
                else if (idx_d == aad_d) phase_d = 3'b000;
                else                     phase_d = 3'b001;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            aad_q    <= '0;
            fin_q    <= '0;
            valid_q  <= 1'b0;
            worker_q <= 4'b0;
            phase_q  <= 3'b100;
            new_q    <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            aad_q    <= aad_d;
            fin_q    <= fin_d;
            valid_q  <= valid_d;
            worker_q <= worker_d;
            phase_q  <= phase_d;
            new_q    <= new_d;
            last_q   <= last_d;
            done_q   <= done_d;
            error_q  <= error_d;
            ready_q  <= ready_d;
        end
    end

`ifdef AES_GCM_SCHED_STATS_EN
    logic [31:0] frames_q, frames_d;
    logic [31:0] blocks_q, blocks_d;

    always_comb begin
        frames_d = frames_q + 32'(done_d);
        blocks_d = blocks_q + 32'(issue);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frames_q <= '0;
            blocks_q <= '0;
        end else begin
            frames_q <= frames_d;
            blocks_q <= blocks_d;
        end
    end

    assign o_stat_frames = frames_q;
    assign o_stat_blocks = blocks_q;
`else
    assign o_stat_frames = 32'd0;
    assign o_stat_blocks = 32'd0;
`endif

    assign o_ready         = ready_q;
    assign o_valid         = valid_q;
    assign o_block_idx     = idx_q;
    assign o_worker_id     = worker_q;
    assign o_phase         = phase_q;
    assign o_new_instance  = new_q;
    assign o_last_instance = last_q;
    assign o_done          = done_q;
    assign o_error         = error_q;

endmodule

// File: tb/tb_aes_gcm_block_scheduler.sv
// Randomized self-checking bench for aes_gcm_block_scheduler: each frame's descriptor list is
// derived from the length arithmetic into an expected queue and compared block by block.
module tb_aes_gcm_block_scheduler;

    localparam int NW   = 2;
    localparam int MAXB = 100000;
    localparam int CW   = 17;
    localparam int DW   = CW + 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic          o_ready;
    logic [127:0]  i_instance_size;
    logic          i_stall;
    logic          i_abort;
    logic          o_valid;
    logic [CW-1:0] o_block_idx;
    logic [3:0]    o_worker_id;
    logic [2:0]    o_phase;
    logic          o_new_instance;
    logic          o_last_instance;
    logic          o_done;
    logic          o_error;
    logic [31:0]   o_stat_frames;
    logic [31:0]   o_stat_blocks;

    int            n_vec = 0;
    int            n_err = 0;
    longint        exp_frames = 0;
    longint        exp_blocks = 0;
    logic [DW-1:0] exp_q[$];

    aes_gcm_block_scheduler #(.NUM_WORKERS(NW), .MAX_BLOCKS(MAXB), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .o_ready(o_ready),
        .i_instance_size(i_instance_size), .i_stall(i_stall), .i_abort(i_abort),
        .o_valid(o_valid), .o_block_idx(o_block_idx), .o_worker_id(o_worker_id),
        .o_phase(o_phase), .o_new_instance(o_new_instance), .o_last_instance(o_last_instance),
        .o_done(o_done), .o_error(o_error), .o_stat_frames(o_stat_frames),
        .o_stat_blocks(o_stat_blocks)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] stat_exp(input longint v);
`ifdef AES_GCM_SCHED_STATS_EN
        return v[31:0];
`else
        return (v == v) ? 32'd0 : 32'd1;
`endif
    endfunction

    // Descriptor for block i, straight from the phase table.
    function automatic logic [DW-1:0] desc(input logic [63:0] i, input logic [63:0] aadb,
                                           input logic [63:0] tot);
        logic [2:0] ph;
        logic [3:0] wk;
        logic [CW-1:0] ix;
        if (i == tot - 1) begin
            if (i > aadb)       ph = 3'b011;
            else if (i == aadb) ph = 3'b111;
            else                ph = 3'b110;
        end else begin
            if (i < aadb)       ph = 3'b010;
            else if (i == aadb) ph = 3'b000;
            else                ph = 3'b001;
        end
        wk = 4'(i % NW);
        ix = CW'(i);
        return {ix, wk, ph, (i == 0), (i == tot - 1)};
    endfunction

    task automatic check_reset_vals();
        check("rst_valid", o_valid, 0);
        check("rst_idx", o_block_idx, 0);
        check("rst_worker", o_worker_id, 0);
        check("rst_phase", o_phase, 3'b100);
        check("rst_new", o_new_instance, 0);
        check("rst_last", o_last_instance, 0);
        check("rst_done", o_done, 0);
        check("rst_error", o_error, 0);
        check("rst_ready", o_ready, 1);
        check("rst_stat_frames", o_stat_frames, 0);
        check("rst_stat_blocks", o_stat_blocks, 0);
    endtask

    task automatic check_stats();
        check("stat_frames", o_stat_frames, stat_exp(exp_frames));
        check("stat_blocks", o_stat_blocks, stat_exp(exp_blocks));
    endtask

    // stall_mode: 0 none, 1 random (plus stray i_start), 2 three stalls at idx 2.
    // abort_at: block index at which i_abort is raised, -1 for none.
    task automatic run_frame(input logic [63:0] aad, input logic [63:0] txt,
                             input int stall_mode, input int abort_at);
        logic [63:0] tot, aadb;
        logic [CW-1:0] cur;
        int cyc, stalls;
        logic st;
        check("ready_before", o_ready, 1);
        i_instance_size = {txt, aad};
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tot  = (aad + txt) >> 7;
        aadb = aad >> 7;
        if (tot > MAXB) begin
            check("err_pulse", o_error, 1);
            check("err_valid", o_valid, 0);
            check("err_done", o_done, 0);
            tick();
            check("err_clear", o_error, 0);
            check("err_ready", o_ready, 1);
            return;
        end
        if (tot == 0) begin
            check("zero_done", o_done, 1);
            check("zero_valid", o_valid, 0);
            exp_frames++;
            tick();
            check("zero_done_clear", o_done, 0);
            check("zero_ready", o_ready, 1);
            return;
        end
        for (longint i = 0; i < longint'(tot); i++) exp_q.push_back(desc(64'(i), aadb, tot));
        cyc = 0;
        stalls = 0;
        while (exp_q.size() > 0 && cyc < 1000) begin
            check("valid", o_valid, 1);
            check("desc", {o_block_idx, o_worker_id, o_phase, o_new_instance, o_last_instance},
                  exp_q[0]);
            cur = exp_q[0][DW-1 -: CW];
            if (abort_at >= 0 && int'(cur) == abort_at) begin
                i_abort = 1'b1;
                i_stall = 1'b1;
                i_start = 1'b1;
                tick();
                i_abort = 1'b0;
                i_stall = 1'b0;
                i_start = 1'b0;
                check("abort_valid", o_valid, 0);
                check("abort_done", o_done, 0);
                check("abort_ready", o_ready, 1);
                exp_q.delete();
                return;
            end
            case (stall_mode)
                1:       st = ($urandom_range(0, 3) == 0);
                2:       st = (cur == 2 && stalls < 3);
                default: st = 1'b0;
            endcase
            i_stall = st;
            if (stall_mode == 1) i_start = 1'($urandom_range(0, 1));
            tick();
            i_stall = 1'b0;
            i_start = 1'b0;
            cyc++;
            if (st) stalls++;
            else begin
                void'(exp_q.pop_front());
                exp_blocks++;
            end
        end
        check("frame_cycles", 64'(cyc), tot + 64'(stalls));
        if (stall_mode == 2) check("stall_count", 64'(stalls), 3);
        exp_q.delete();
        check("done_pulse", o_done, 1);
        check("done_valid", o_valid, 0);
        exp_frames++;
        tick();
        check("done_clear", o_done, 0);
        check("done_ready", o_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_stall = 1'b0;
        i_abort = 1'b0;
        i_instance_size = '0;
        tick();
        tick();
        check_reset_vals();
        rst = 1'b0;
        tick();

        // two frames, then statistics (2 frames / 6 blocks when counting is built in)
        run_frame(64'd256, 64'd384, 0, -1);
        run_frame(64'd0, 64'd128, 0, -1);
        check_stats();

        run_frame(64'd256, 64'd0, 0, -1);
        run_frame(64'd100001 * 64'd128, 64'd0, 0, -1);
        run_frame(64'd0, 64'd0, 0, -1);
        run_frame(64'd100, 64'd27, 0, -1);
        run_frame(64'd300, 64'd200, 0, -1);
        run_frame(64'd256, 64'd384, 2, -1);
        run_frame(64'd256, 64'd384, 0, 1);
        run_frame(64'd0, 64'd384, 0, -1);
        check_stats();

        // reset in the middle of a frame
        i_instance_size = {64'd1280, 64'd0};
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_reset_vals();
        rst = 1'b0;
        exp_frames = 0;
        exp_blocks = 0;
        tick();
        check("post_rst_done", o_done, 0);

        for (int n = 0; n < 40; n++) begin
            int ab;
            ab = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_frame(64'($urandom_range(0, 1500)), 64'($urandom_range(0, 1500)),
                      int'($urandom_range(0, 1)), ab);
            if ($urandom_range(0, 2) == 0) tick();
        end
        check_stats();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
